// File: rtl/click_counter_display.sv
`default_nettype none
// ============================================================================
// Module      : click_counter_display
// Description : Counts rising edges of a debounced click level in 3-digit
//               BCD (000-999) and drives a 3-digit multiplexed, active-low
//               seven-segment display. A 999 -> 000 wrap sets a sticky
//               overflow LED that only reset clears.
//
// Ports       : clk   - system clock, all state updates on the rising edge
//               rst   - synchronous active-high reset
//               click - debounced click level, synchronous to clk
//               seg   - segment drive, active-low, [0]=a .. [6]=g, [7]=dp
//               an    - digit enables, active-low one-hot
//                       ([0]=ones, [1]=tens, [2]=hundreds)
//               led   - led[0] is the sticky overflow flag
//
// Parameters  : REFRESH_DIV - clock cycles each digit stays lit (2 .. 2^20)
//
// Revision    : 1.0 - initial release
// ============================================================================
module click_counter_display #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       click,
   output logic [7:0] seg,
   output logic [2:0] an,
   output logic [0:0] led
);

   // Refresh counter width: enough to hold REFRESH_DIV-1.
   localparam int              c_RW   = $clog2(REFRESH_DIV);
   localparam logic [c_RW-1:0] c_RMAX = c_RW'(REFRESH_DIV - 1);

   // Digit-select states.
   localparam logic [1:0] c_SEL_ONES = 2'd0;
   localparam logic [1:0] c_SEL_TENS = 2'd1;
   localparam logic [1:0] c_SEL_HUND = 2'd2;

   localparam logic [3:0] c_NINE = 4'd9;

   logic            r_click_q;
   logic [3:0]      r_d0;
   logic [3:0]      r_d1;
   logic [3:0]      r_d2;
   logic            r_ovf;
   logic [c_RW-1:0] r_rcnt;
   logic [1:0]      r_sel;

   logic            w_evt;
   logic [3:0]      w_digit;
   logic [2:0]      w_an;

   // Active-low seven-segment encoding; anything outside 0-9 blanks.
   function automatic logic [7:0] f_encode(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   assign w_evt = click & ~r_click_q;

   // ------------------------------------------------------------------------
   // Edge detector. Loading click during reset means a button held through
   // reset release does not look like a fresh press.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      r_click_q <= click;
   end

   // ------------------------------------------------------------------------
   // BCD counter with ripple carry and sticky overflow.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_d0  <= 4'd0;
         r_d1  <= 4'd0;
         r_d2  <= 4'd0;
         r_ovf <= 1'b0;
      end else if (w_evt) begin
         if (r_d0 >= c_NINE) begin
            r_d0 <= 4'd0;
            if (r_d1 >= c_NINE) begin
               r_d1 <= 4'd0;
               if (r_d2 >= c_NINE) begin
                  r_d2  <= 4'd0;
                  r_ovf <= 1'b1;
               end else begin
                  r_d2 <= r_d2 + 4'd1;
               end
            end else begin
               r_d1 <= r_d1 + 4'd1;
            end
         end else begin
            r_d0 <= r_d0 + 4'd1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Refresh divider and digit select (0 -> 1 -> 2 -> 0).
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rcnt <= '0;
         r_sel  <= c_SEL_ONES;
      end else if (r_rcnt == c_RMAX) begin
         r_rcnt <= '0;
         case (r_sel)
            c_SEL_ONES: r_sel <= c_SEL_TENS;
            c_SEL_TENS: r_sel <= c_SEL_HUND;
            default:    r_sel <= c_SEL_ONES;
         endcase
      end else begin
         r_rcnt <= r_rcnt + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Output stage: registered from the current select/digits, so the pins
   // show the state left by the previous edge.
   // ------------------------------------------------------------------------
   always_comb begin
      w_digit = 4'hF;
      w_an    = 3'b111;
      case (r_sel)
         c_SEL_ONES: begin w_digit = r_d0; w_an = 3'b110; end
         c_SEL_TENS: begin w_digit = r_d1; w_an = 3'b101; end
         c_SEL_HUND: begin w_digit = r_d2; w_an = 3'b011; end
         default:    begin w_digit = 4'hF; w_an = 3'b111; end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seg <= 8'hFF;
         an  <= 3'b111;
         led <= 1'b0;
      end else begin
         seg <= f_encode(w_digit) | 8'h80;
         an  <= w_an;
         led <= r_ovf;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_click_counter_display.sv
`default_nettype none
// ============================================================================
// Module      : tb_click_counter_display
// Description : Scoreboard bench for click_counter_display. The stimulus
//               process drives one cycle at a time and queues the output
//               expected after that edge; a monitor pops and compares each
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_click_counter_display;

   localparam int c_DIV = 4;

   logic       clk;
   logic       rst;
   logic       click;
   logic [7:0] seg;
   logic [2:0] an;
   logic [0:0] led;

   typedef struct {
      logic [7:0] seg;
      logic [2:0] an;
      logic       led;
      int         ph;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   errors;

   // Reference state: plain integer count, decimal digits by division.
   int   m_count;
   int   m_ovf;
   int   m_clickq;
   int   m_rcnt;
   int   m_sel;

   click_counter_display #(.REFRESH_DIV(c_DIV)) dut (
      .clk   (clk),
      .rst   (rst),
      .click (click),
      .seg   (seg),
      .an    (an),
      .led   (led)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] enc(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   function automatic logic [2:0] an_of(input int s);
      case (s)
         0: return 3'b110;
         1: return 3'b101;
         2: return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

   function automatic int digit_of(input int cnt, input int s);
      case (s)
         0: return cnt % 10;
         1: return (cnt / 10) % 10;
         2: return (cnt / 100) % 10;
         default: return 15;
      endcase
   endfunction

   // Drive one cycle's inputs and queue what the pins must show after it.
   task automatic step(input logic c, input logic r, input int ph);
      exp_t e;
      @(negedge clk);
      click = c;
      rst   = r;
      if (r) begin
         e.seg   = 8'hFF;
         e.an    = 3'b111;
         e.led   = 1'b0;
         m_count = 0;
         m_ovf   = 0;
         m_rcnt  = 0;
         m_sel   = 0;
      end else begin
         e.an  = an_of(m_sel);
         e.seg = enc(digit_of(m_count, m_sel));
         e.led = (m_ovf != 0);
         if (c && m_clickq == 0) begin
            m_count = m_count + 1;
            if (m_count == 1000) begin
               m_count = 0;
               m_ovf   = 1;
            end
         end
         if (m_rcnt == c_DIV - 1) begin
            m_rcnt = 0;
            m_sel  = (m_sel + 1) % 3;
         end else begin
            m_rcnt = m_rcnt + 1;
         end
      end
      m_clickq = c ? 1 : 0;
      e.ph     = ph;
      sb.push_back(e);
   endtask

   task automatic pulse(input int ph);
      step(1'b1, 1'b0, ph);
      step(1'b0, 1'b0, ph);
   endtask

   task automatic idle(input int n, input int ph);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, ph);
   endtask

   task automatic do_reset(input int n, input int ph);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, ph);
   endtask

   // Monitor: compare one queued expectation per clock edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         checks++;
         if (seg !== e.seg || an !== e.an || led[0] !== e.led) begin
            errors++;
            $display("FAIL phase%0d @%0t: seg=%h an=%b led=%b, expected seg=%h an=%b led=%b",
                     e.ph, $time, seg, an, led[0], e.seg, e.an, e.led);
         end
      end
   end

   // Watchdog.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin
      checks   = 0;
      errors   = 0;
      m_count  = 0;
      m_ovf    = 0;
      m_clickq = 0;
      m_rcnt   = 0;
      m_sel    = 0;
      rst      = 1'b1;
      click    = 1'b0;

      // 1: reset held three cycles.
      do_reset(3, 1);
      // 2: scan with no clicks (110x4, 101x4, 011x4, seg C0).
      idle(24, 2);
      // 3: single click held 10 cycles -> 001.
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 3);
      idle(12, 3);
      // 4: carry, 10 pulses from 000 -> 010.
      do_reset(2, 4);
      for (int i = 0; i < 10; i++) pulse(4);
      idle(12, 4);
      // 5: wrap, 1000 pulses -> 000 with led, then one more -> 001.
      do_reset(2, 5);
      for (int i = 0; i < 1000; i++) pulse(5);
      idle(12, 5);
      pulse(5);
      idle(12, 5);
      // 6: reset mid-count with button held through release.
      do_reset(2, 6);
      for (int i = 0; i < 123; i++) pulse(6);
      idle(12, 6);
      step(1'b1, 1'b0, 6);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6);
      for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 6);
      step(1'b0, 1'b0, 6);
      step(1'b1, 1'b0, 6);
      idle(12, 6);

      @(posedge clk);
      #3;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/click_counter_display.md
# click_counter_display

Downstream consumer of the debounced click signal from the button-filter stage. It counts rising edges of the filtered click in 3-digit BCD (000–999) and drives the 3-digit multiplexed seven-segment display (`seg`, `an`). A wrap from 999 to 000 sets a sticky overflow LED. It sits between the button filters and the board pins in the top level.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range is 2 to 2^20. Use 4 in simulation.
- `clk` in 1: system clock. All state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high. Driven from the filtered reset button.
- `click` in 1: debounced click level from the button filter. It is synchronous to `clk`.
- `seg` out 8: segment drive, active-low. Bit map: `seg[0]`=a … `seg[6]`=g, `seg[7]`=dp.
- `an` out 3: digit enables, active-low, one-hot. `an[0]` = ones, `an[1]` = tens, `an[2]` = hundreds.
- `led` out 1: `led[0]` is the sticky overflow flag.

## Operation
- **Edge detection**
  - `click_q` is a one-cycle delayed copy of `click`.
  - A count event occurs when `click`=1 and `click_q`=0.
  - During `rst`, `click_q` loads `click`. A button held through reset release therefore produces no count.
- **BCD counter**
  - Three 4-bit digits d0 (ones), d1 (tens), d2 (hundreds). Each digit stays within 0–9 at all times.
  - On a count event, d0 increments. On 9→0, d1 carries; on d1 9→0, d2 carries.
  - On 999 a count event gives 000 and sets the overflow flag.
  - The overflow flag clears only on `rst`.
- **Refresh counter**
  - `rcnt` counts 0 … REFRESH_DIV-1, then wraps to 0.
  - When `rcnt` = REFRESH_DIV-1, the digit select `sel` advances 0→1→2→0. The value `sel`=3 is never reached.
- **Output stage** (registered)
  - `an` ← ~(1<<sel): sel 0 → 3'b110, sel 1 → 3'b101, sel 2 → 3'b011.
  - `seg` ← encode(digit[sel]), with `seg[7]`=1 (dp off).
- **Encoding** (active-low)
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Any other value → FF. This is defensive only and unreachable.
  - Leading zeros are displayed.
- **Reset values**
  - d2,d1,d0 = 0; overflow = 0; `rcnt` = 0; `sel` = 0.
  - `seg` = 8'hFF, `an` = 3'b111, `led` = 1'b0.

## Timing
- A count event seen at edge k updates the digits at edge k. The registered `seg` reflects the new value at edge k+1, if that digit is selected.
- The event → `led` set path has the same latency: flag at edge k, `led` at edge k+1.
- First edge with `rst`=0: `sel`=0, `rcnt`=1, `an`=3'b110, `seg`=8'hC0.
- Each digit is lit for exactly REFRESH_DIV cycles. Full scan period is 3·REFRESH_DIV cycles.
- **Simultaneous events:**
  - A count event coinciding with a `sel` advance is applied normally.
  - The output stage always shows the post-edge `sel` and post-edge digits one cycle later.
  - No event is lost.
- `click` held high for many cycles gives exactly one count. Each new 0→1 transition counts, with a minimum spacing of 2 cycles.
- **`rst` asserted mid-operation:** everything returns to reset values at that edge. Blank display (`an`=111) holds for as long as `rst` is high.

## Test plan
- **Reset:** REFRESH_DIV=4, hold `rst` 3 cycles, release.
  - During reset: `an`=111, `seg`=FF, `led`=0.
  - First edge after release: `an`=110, `seg`=C0.
- **Scan:** no clicks over 24 cycles.
  - `an` sequence is 110×4, 101×4, 011×4, repeating.
  - `seg` is always C0.
- **Single click held 10 cycles:** count=001.
  - `seg`=F9 while `an`=110; `seg`=C0 while `an`=101 or 011.
- **Carry:** apply 10 pulses (1 high, 1 low each).
  - Count=010: ones digit `seg`=C0, tens digit `seg`=F9.
- **Wrap:** 1000 pulses.
  - Count=000, `led`=1.
  - One further pulse: count=001, `led` stays 1.
- **Reset mid-count with button held:** count=123, then assert `rst` while `click`=1 and release with `click` still 1.
  - Count=000, `led`=0, and no increment until `click` falls and rises again.
